// File: rtl/apb2iob_tmo.sv
// APB3 slave to IOb master bridge with PSLVERR, a wait-state timeout and an optional address limit.
// The timeout guarantees that a hung or absent IOb peripheral cannot stall the APB master forever.
module apb2iob_tmo #(
  parameter int APB_ADDR_W = 21,
  parameter int APB_DATA_W = 32,
  parameter int ADDR_W     = APB_ADDR_W,
  parameter int DATA_W     = APB_DATA_W,
  parameter int TIMEOUT_W  = 8,
  parameter int TIMEOUT    = 255,
  parameter int ADDR_LIMIT = 0,
  parameter int STRB_EN    = 1
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic                    apb_sel_i,
  input  logic                    apb_enable_i,
  input  logic                    apb_write_i,
  input  logic [APB_ADDR_W-1:0]   apb_addr_i,
  input  logic [APB_DATA_W-1:0]   apb_wdata_i,
  input  logic [APB_DATA_W/8-1:0] apb_wstrb_i,
  output logic [APB_DATA_W-1:0]   apb_rdata_o,
  output logic                    apb_ready_o,
  output logic                    apb_slverr_o,
  output logic                    iob_valid_o,
  output logic [ADDR_W-1:0]       iob_addr_o,
  output logic [DATA_W-1:0]       iob_wdata_o,
  output logic [DATA_W/8-1:0]     iob_wstrb_o,
  input  logic                    iob_ready_i,
  input  logic                    iob_rvalid_i,
  input  logic [DATA_W-1:0]       iob_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_READY,
    WAIT_RVALID,
    RESP
  } state_t;

  localparam logic [APB_ADDR_W-1:0] ADDR_LIMIT_V = APB_ADDR_W'(ADDR_LIMIT);
  localparam logic [TIMEOUT_W-1:0]  TMO_LAST     = TIMEOUT_W'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    slverr_q, slverr_d;
  logic [APB_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    valid_c;
  logic                    req;
  logic                    addr_bad;
  logic                    tmo_hit;

  assign req      = apb_sel_i & apb_enable_i;
  assign addr_bad = (ADDR_LIMIT != 0) && (apb_addr_i >= ADDR_LIMIT_V);
  assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  assign iob_addr_o  = apb_addr_i[ADDR_W-1:0];
  assign iob_wdata_o = apb_wdata_i;
  assign iob_wstrb_o = apb_write_i ? ((STRB_EN != 0) ? apb_wstrb_i : '1) : '0;

  // Gated by reset so an aborted transfer withdraws its request immediately.
  assign iob_valid_o = arst_n_i & valid_c;

  assign apb_ready_o  = ready_q;
  assign apb_slverr_o = slverr_q;
  assign apb_rdata_o  = rdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = rdata_q;
    valid_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = '0;
          if (addr_bad) begin
            state_d  = RESP;
            ready_d  = 1'b1;
            slverr_d = 1'b1;
          end else begin
            valid_c = 1'b1;
            if (iob_ready_i) begin
              if (apb_write_i) begin
                state_d = RESP;
                ready_d = 1'b1;
              end else begin
                state_d = WAIT_RVALID;
              end
            end else begin
              state_d = WAIT_READY;
            end
          end
        end
      end
      WAIT_READY: begin
        valid_c = 1'b1;
        cnt_d   = cnt_q + TIMEOUT_W'(1);
        if (iob_ready_i) begin
          if (apb_write_i) begin
            state_d = RESP;
            ready_d = 1'b1;
          end else begin
            state_d = WAIT_RVALID;
          end
        end else if (tmo_hit) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          if (!apb_write_i) begin
            rdata_d = '0;
          end
        end
      end
      WAIT_RVALID: begin
        // The counter carries on from the address phase, so the budget covers the whole transfer.
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (iob_rvalid_i) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = iob_rdata_i;
        end else if (tmo_hit) begin
          state_d  = RESP;
          ready_d  = 1'b1;
          slverr_d = 1'b1;
          rdata_d  = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_apb2iob_tmo.sv
// Directed bench for apb2iob_tmo: dutA uses default parameters, dutB a short timeout,
// an address limit of 0x100 and no PSTRB. Each dut has its own PSEL; the other inputs are shared.
module tb_apb2iob_tmo;

  logic        clk;
  logic        cke;
  logic        arstN;
  logic        selA, selB, enable, write;
  logic [20:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        iobReady, iobRvalid;
  logic [31:0] iobRdata;

  logic [31:0] rdataA, rdataB;
  logic        readyA, readyB, slverrA, slverrB, validA, validB;
  logic [20:0] iobAddrA, iobAddrB;
  logic [31:0] iobWdataA, iobWdataB;
  logic [3:0]  iobWstrbA, iobWstrbB;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  apb2iob_tmo dutA (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arstN),
    .apb_sel_i(selA), .apb_enable_i(enable), .apb_write_i(write),
    .apb_addr_i(addr), .apb_wdata_i(wdata), .apb_wstrb_i(wstrb),
    .apb_rdata_o(rdataA), .apb_ready_o(readyA), .apb_slverr_o(slverrA),
    .iob_valid_o(validA), .iob_addr_o(iobAddrA), .iob_wdata_o(iobWdataA),
    .iob_wstrb_o(iobWstrbA), .iob_ready_i(iobReady), .iob_rvalid_i(iobRvalid),
    .iob_rdata_i(iobRdata)
  );

  apb2iob_tmo #(.TIMEOUT(4), .ADDR_LIMIT(32'h100), .STRB_EN(0)) dutB (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arstN),
    .apb_sel_i(selB), .apb_enable_i(enable), .apb_write_i(write),
    .apb_addr_i(addr), .apb_wdata_i(wdata), .apb_wstrb_i(wstrb),
    .apb_rdata_o(rdataB), .apb_ready_o(readyB), .apb_slverr_o(slverrB),
    .iob_valid_o(validB), .iob_addr_o(iobAddrB), .iob_wdata_o(iobWdataB),
    .iob_wstrb_o(iobWstrbB), .iob_ready_i(iobReady), .iob_rvalid_i(iobRvalid),
    .iob_rdata_i(iobRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus cycle: inputs change 1ns after the rising edge, outputs are sampled 1ns later.
  task automatic applyStimulus(input logic sA, input logic sB, input logic en, input logic wr,
                               input logic [20:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               input logic rdy, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    selA = sA; selB = sB; enable = en; write = wr;
    addr = a; wdata = wd; wstrb = ws;
    iobReady = rdy; iobRvalid = rv; iobRdata = rd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) begin
      nPass++;
    end else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    arstN = 1'b0; cke = 1'b1;
    selA = 0; selB = 0; enable = 0; write = 0; addr = '0; wdata = '0; wstrb = '0;
    iobReady = 0; iobRvalid = 0; iobRdata = '0;

    // reset state
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rst_readyA", readyA, 0);
    checkOutput("rst_slverrA", slverrA, 0);
    checkOutput("rst_rdataA", rdataA, 0);
    checkOutput("rst_validA", validA, 0);
    checkOutput("rst_readyB", readyB, 0);
    checkOutput("rst_rdataB", rdataB, 0);
    arstN = 1'b1;

    // dutA write, immediate ready: one valid cycle, PREADY next cycle
    applyStimulus(1, 0, 0, 1, 21'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h0);
    checkOutput("wr_setup_valid", validA, 0);
    applyStimulus(1, 0, 1, 1, 21'h10, 32'hA5A5A5A5, 4'hF, 1, 0, 32'h0);
    checkOutput("wr_valid", validA, 1);
    checkOutput("wr_wstrb", iobWstrbA, 4'hF);
    checkOutput("wr_addr", iobAddrA, 21'h10);
    checkOutput("wr_wdata", iobWdataA, 32'hA5A5A5A5);
    checkOutput("wr_ready_early", readyA, 0);
    applyStimulus(1, 0, 1, 1, 21'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h0);
    checkOutput("wr_ready", readyA, 1);
    checkOutput("wr_slverr", slverrA, 0);
    checkOutput("wr_resp_valid", validA, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("wr_ready_drop", readyA, 0);

    // dutA read: ready after 3 wait cycles, rvalid 2 cycles later
    applyStimulus(1, 0, 0, 0, 21'h20, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rd_valid_c0", validA, 1);
    checkOutput("rd_wstrb", iobWstrbA, 0);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rd_valid_c1", validA, 1);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rd_valid_c2", validA, 1);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("rd_valid_c3", validA, 1);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rd_valid_c4", validA, 0);
    checkOutput("rd_ready_c4", readyA, 0);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 0, 1, 32'h12345678);
    checkOutput("rd_ready_c5", readyA, 0);
    applyStimulus(1, 0, 1, 0, 21'h20, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rd_ready", readyA, 1);
    checkOutput("rd_slverr", slverrA, 0);
    checkOutput("rd_rdata", rdataA, 32'h12345678);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rd_ready_drop", readyA, 0);
    checkOutput("rd_rdata_hold", rdataA, 32'h12345678);

    // dutB write without PSTRB; ready coincides with the timeout cycle
    applyStimulus(0, 1, 0, 1, 21'h40, 32'h11223344, 4'h1, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h40, 32'h11223344, 4'h1, 0, 0, 32'h0);
    checkOutput("nostrb_valid", validB, 1);
    checkOutput("nostrb_wstrb", iobWstrbB, 4'hF);
    checkOutput("nostrb_addr", iobAddrB, 21'h40);
    checkOutput("nostrb_wdata", iobWdataB, 32'h11223344);
    applyStimulus(0, 1, 1, 1, 21'h40, 32'h11223344, 4'h1, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h40, 32'h11223344, 4'h1, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h40, 32'h11223344, 4'h1, 0, 0, 32'h0);
    checkOutput("coinc_wr_ready_c3", readyB, 0);
    applyStimulus(0, 1, 1, 1, 21'h40, 32'h11223344, 4'h1, 1, 0, 32'h0);
    checkOutput("coinc_wr_valid_c4", validB, 1);
    applyStimulus(0, 1, 1, 1, 21'h40, 32'h11223344, 4'h1, 0, 0, 32'h0);
    checkOutput("coinc_wr_ready", readyB, 1);
    checkOutput("coinc_wr_slverr", slverrB, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);

    // dutB read; rvalid coincides with the timeout cycle
    applyStimulus(0, 1, 0, 0, 21'h44, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h44, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("coinc_rd_wstrb", iobWstrbB, 0);
    applyStimulus(0, 1, 1, 0, 21'h44, 32'h0, 4'h0, 1, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h44, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h44, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("coinc_rd_ready_c3", readyB, 0);
    applyStimulus(0, 1, 1, 0, 21'h44, 32'h0, 4'h0, 0, 1, 32'hCAFEF00D);
    applyStimulus(0, 1, 1, 0, 21'h44, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("coinc_rd_ready", readyB, 1);
    checkOutput("coinc_rd_slverr", slverrB, 0);
    checkOutput("coinc_rd_rdata", rdataB, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);

    // dutB read above the address limit: no IOb request, error one cycle after enable
    applyStimulus(0, 1, 0, 0, 21'h180, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("lim_setup_valid", validB, 0);
    applyStimulus(0, 1, 1, 0, 21'h180, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("lim_valid", validB, 0);
    applyStimulus(0, 1, 1, 0, 21'h180, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("lim_ready", readyB, 1);
    checkOutput("lim_slverr", slverrB, 1);
    checkOutput("lim_rdata", rdataB, 32'hCAFEF00D);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("lim_ready_drop", readyB, 0);
    checkOutput("lim_slverr_drop", slverrB, 0);

    // dutB read accepted at once, rvalid never comes: timeout clears read data
    applyStimulus(0, 1, 0, 0, 21'h50, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h50, 32'h0, 4'h0, 1, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h50, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h50, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h50, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 0, 21'h50, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rtmo_ready_c4", readyB, 0);
    applyStimulus(0, 1, 1, 0, 21'h50, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rtmo_ready", readyB, 1);
    checkOutput("rtmo_slverr", slverrB, 1);
    checkOutput("rtmo_rdata", rdataB, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);

    // dutB write, iob ready never: five valid cycles, then error; late ready ignored
    applyStimulus(0, 1, 0, 1, 21'h60, 32'h55AA55AA, 4'h3, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h60, 32'h55AA55AA, 4'h3, 0, 0, 32'h0);
    checkOutput("wtmo_valid_c0", validB, 1);
    applyStimulus(0, 1, 1, 1, 21'h60, 32'h55AA55AA, 4'h3, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h60, 32'h55AA55AA, 4'h3, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h60, 32'h55AA55AA, 4'h3, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 21'h60, 32'h55AA55AA, 4'h3, 0, 0, 32'h0);
    checkOutput("wtmo_valid_c4", validB, 1);
    checkOutput("wtmo_ready_c4", readyB, 0);
    applyStimulus(0, 1, 1, 1, 21'h60, 32'h55AA55AA, 4'h3, 1, 0, 32'h0);
    checkOutput("wtmo_ready", readyB, 1);
    checkOutput("wtmo_slverr", slverrB, 1);
    checkOutput("wtmo_valid_resp", validB, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("late_ready_ready", readyB, 0);
    checkOutput("late_ready_slverr", slverrB, 0);
    checkOutput("late_ready_valid", validB, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("late_ready_ready2", readyB, 0);
    checkOutput("wtmo_rdata", rdataB, 0);

    // dutA clock enable: a frozen cycle delays the accept and stretches the response
    applyStimulus(1, 0, 0, 1, 21'h70, 32'h0BADBEEF, 4'hF, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 1, 21'h70, 32'h0BADBEEF, 4'hF, 1, 0, 32'h0);
    cke = 1'b0;
    checkOutput("cke_valid_frozen", validA, 1);
    applyStimulus(1, 0, 1, 1, 21'h70, 32'h0BADBEEF, 4'hF, 1, 0, 32'h0);
    cke = 1'b1;
    checkOutput("cke_ready_frozen", readyA, 0);
    checkOutput("cke_valid_again", validA, 1);
    applyStimulus(1, 0, 1, 1, 21'h70, 32'h0BADBEEF, 4'hF, 0, 0, 32'h0);
    cke = 1'b0;
    checkOutput("cke_ready", readyA, 1);
    applyStimulus(1, 0, 1, 1, 21'h70, 32'h0BADBEEF, 4'hF, 0, 0, 32'h0);
    cke = 1'b1;
    checkOutput("cke_ready_held", readyA, 1);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("cke_ready_drop", readyA, 0);
    checkOutput("cke_rdata_unchanged", rdataA, 32'h12345678);

    // dutA reset in WAIT_RVALID aborts at once, then a normal write completes
    applyStimulus(1, 0, 0, 0, 21'h30, 32'h0, 4'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 21'h30, 32'h0, 4'h0, 1, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 21'h30, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("rst_mid_valid_before", validA, 0);
    arstN = 1'b0;
    #1;
    checkOutput("rst_mid_ready", readyA, 0);
    checkOutput("rst_mid_slverr", slverrA, 0);
    checkOutput("rst_mid_rdata", rdataA, 0);
    checkOutput("rst_mid_valid", validA, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    arstN = 1'b1;
    applyStimulus(1, 0, 0, 1, 21'h14, 32'h600DF00D, 4'hF, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 1, 21'h14, 32'h600DF00D, 4'hF, 1, 0, 32'h0);
    checkOutput("post_rst_valid", validA, 1);
    applyStimulus(1, 0, 1, 1, 21'h14, 32'h600DF00D, 4'hF, 0, 0, 32'h0);
    checkOutput("post_rst_ready", readyA, 1);
    checkOutput("post_rst_slverr", slverrA, 0);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 1, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 21'h0, 32'h0, 4'h0, 0, 0, 32'h0);
    checkOutput("idle_rvalid_ready", readyA, 0);
    checkOutput("idle_rvalid_rdata", rdataA, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/apb2iob_tmo.md
Name: apb2iob_tmo

Overview:
APB3 slave to IOb master bridge. It is the parametrised successor of the basic APB-to-IOb bridge and adds three things: PSLVERR generation, a programmable wait-state timeout, and an optional address-limit check. It sits between the system APB interconnect and IOb peripherals, so that a hung or absent peripheral cannot stall the APB master forever.

Parameters:
APB_ADDR_W, 21, APB address width
APB_DATA_W, 32, APB data width (multiple of 8)
ADDR_W, APB_ADDR_W, IOb address width (<= APB_ADDR_W; low bits of paddr forwarded)
DATA_W, APB_DATA_W, IOb data width (must equal APB_DATA_W)
TIMEOUT_W, 8, timeout counter width
TIMEOUT, 255, wait cycles before error; 0 disables the timeout
ADDR_LIMIT, 0, addresses >= ADDR_LIMIT are rejected with an error; 0 disables the check
STRB_EN, 1, 1: use apb_wstrb_i; 0: writes drive all-ones strobe (APB2/3 masters without PSTRB)

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; all registers hold when 0
arst_n_i  in  1  asynchronous reset, active-low
apb_sel_i  in  1  PSEL
apb_enable_i  in  1  PENABLE
apb_write_i  in  1  PWRITE
apb_addr_i  in  APB_ADDR_W  PADDR
apb_wdata_i  in  APB_DATA_W  PWDATA
apb_wstrb_i  in  APB_DATA_W/8  PSTRB
apb_rdata_o  out  APB_DATA_W  PRDATA (registered)
apb_ready_o  out  1  PREADY (registered)
apb_slverr_o  out  1  PSLVERR (registered, meaningful only with apb_ready_o)
iob_valid_o  out  1  IOb request valid
iob_addr_o  out  ADDR_W  apb_addr_i[ADDR_W-1:0]
iob_wdata_o  out  DATA_W  apb_wdata_i passthrough
iob_wstrb_o  out  DATA_W/8  write strobe; 0 for reads
iob_ready_i  in  1  IOb request accepted
iob_rvalid_i  in  1  IOb read data valid
iob_rdata_i  in  DATA_W  IOb read data

Behaviour:
- Reset (arst_n_i=0, asynchronous): state=IDLE, counter=0, apb_ready_o=0, apb_slverr_o=0, apb_rdata_o=0.
- iob_wstrb_o = apb_write_i ? (STRB_EN ? apb_wstrb_i : all-ones) : 0.
- addr_bad = (ADDR_LIMIT!=0) && (apb_addr_i >= ADDR_LIMIT), compared at full APB_ADDR_W.
- iob_valid_o is combinational: 1 in IDLE when sel&enable&!addr_bad; 1 throughout WAIT_READY; 0 otherwise.

- FSM states: IDLE, WAIT_READY, WAIT_RVALID, RESP.
- IDLE:
  - sel&enable&addr_bad -> RESP with err=1; no IOb request is issued.
  - sel&enable&!addr_bad&iob_ready_i -> write: RESP, err=0; read: WAIT_RVALID.
  - sel&enable&!addr_bad&!iob_ready_i -> WAIT_READY.
  - Counter cleared on every exit from IDLE.
- WAIT_READY:
  - Counter increments each cycle.
  - iob_ready_i -> as the IDLE accept case.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP with err=1; iob_valid_o drops.
- WAIT_RVALID:
  - Counter keeps incrementing; it is not cleared on accept.
  - iob_rvalid_i -> apb_rdata_o<=iob_rdata_i, RESP, err=0.
  - Else on timeout -> apb_rdata_o<=0, RESP, err=1.
- RESP: apb_ready_o=1 and apb_slverr_o=err for exactly one cycle, then IDLE. apb_slverr_o returns to 0 with apb_ready_o.
- Simultaneous events: if ready/rvalid arrives in the same cycle as the timeout, ready/rvalid wins (err=0).
- apb_rdata_o changes only on rvalid capture, a read timeout, or reset. Writes leave it unchanged.
- Late iob_rvalid_i/iob_ready_i after a timeout, or while in IDLE, are ignored with no state change.
- Latency, from the first enable cycle to the apb_ready_o cycle:
  - write with immediate ready: 1 cycle.
  - read with ready immediate and rvalid one cycle later: 2 cycles.
  - general: 1 + ready wait + rvalid wait.
- Back-to-back transfers: APB guarantees penable low after PREADY, so IDLE never re-accepts the completed transfer.
- Reset mid-transaction aborts immediately: iob_valid_o=0 combinationally; no response is given.
- cke_i=0 freezes state, counter and outputs; combinational outputs still follow inputs per the frozen state.

Test Plan:
- Write addr 0x10, data 0xA5A5A5A5, strb 0xF, iob_ready_i=1 in the enable cycle -> iob_valid_o 1 cycle, iob_wstrb_o=0xF, apb_ready_o=1 the next cycle, apb_slverr_o=0.
- Read addr 0x20, ready after 3 cycles, rvalid 2 cycles later with 0x12345678 -> iob_valid_o for 4 cycles, iob_wstrb_o=0, apb_rdata_o=0x12345678, single-cycle apb_ready_o, apb_slverr_o=0.
- TIMEOUT=4, iob_ready_i never asserted -> iob_valid_o for 5 cycles, then apb_ready_o=1 with apb_slverr_o=1; a late iob_ready_i has no effect.
- ADDR_LIMIT=0x100, read at 0x180 -> iob_valid_o never asserted, apb_ready_o=1 and apb_slverr_o=1 one cycle after enable, apb_rdata_o unchanged.
- STRB_EN=0, write with apb_wstrb_i=0x1 -> iob_wstrb_o=0xF; ready and rvalid coincide with the timeout cycle -> err=0.
- Assert arst_n_i=0 in WAIT_RVALID -> apb_ready_o/apb_slverr_o/apb_rdata_o=0 and iob_valid_o=0 immediately; the next transfer completes normally.
